// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles every handshake and bus signal of the two-requester memory
//   arbiter: the instruction-fetch side, the data-access side, the shared
//   memory port, and the pipeline status outputs (stall, err).
//
//   modport slave  : the arbiter's view (takes requests, drives acks/mem_*)
//   modport master : the environment's view (requesters and memory)
interface mem_arbiter_if;
    // fetch side (read-only)
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_ack;
    logic [31:0] f_rdata;
    // data side (read/write)
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    // shared memory port
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    // pipeline status
    logic        stall;
    logic        err;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output f_ack, f_rdata, d_ack, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, stall, err
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  f_ack, f_rdata, d_ack, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, stall, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one variable-latency memory port between instruction fetch
//   (read-only) and data access (read/write). Data has priority; after
//   STARVE_LIMIT consecutive data grants with fetch waiting, fetch is
//   granted. A watchdog aborts a transaction after TIMEOUT cycles with no
//   mem_ack (0 disables it) and raises the sticky err flag.
//
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : mem_arbiter_if.slave -- requester handshakes (f_*, d_*),
//            registered memory request (mem_*), stall and err
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,   // 1..15
    parameter int TIMEOUT      = 64   // 0..255, 0 = watchdog off
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] WD_LAST    = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
    localparam bit         WD_EN      = (TIMEOUT != 0);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  starve_cnt;
    logic [7:0]  wd_cnt;

    logic        grant_f;
    logic        grant_d;
    logic        busy;
    logic        wd_expire;
    logic        done;

    logic        f_ack;
    logic        d_ack;
    logic [31:0] f_rdata;
    logic [31:0] d_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        err;

    assign busy = (state != IDLE);

    // A real mem_ack on the last watchdog cycle wins over the timeout.
    assign wd_expire = WD_EN && busy && (wd_cnt == WD_LAST) && !bus.mem_ack;
    assign done      = busy && (bus.mem_ack || wd_expire);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next state / arbitration ----------------
    always_comb begin
        state_nxt = state;
        grant_f   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                // Data wins unless fetch has waited STARVE_LIMIT data grants.
                if (bus.d_req && !(bus.f_req && starve_cnt == STARVE_MAX)) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (bus.f_req) begin
                    grant_f   = 1'b1;
                    state_nxt = BUSY_F;
                end
            end
            BUSY_F, BUSY_D: begin
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // Acks are combinational so the requester sees them in the mem_ack
    // cycle; a timed-out ack carries zero data.
    always_comb begin
        f_ack   = 1'b0;
        d_ack   = 1'b0;
        f_rdata = 32'd0;
        d_rdata = 32'd0;
        case (state)
            BUSY_F: begin
                f_ack = done;
                if (bus.mem_ack) begin
                    f_rdata = bus.mem_rdata;
                end
            end
            BUSY_D: begin
                d_ack = done;
                if (bus.mem_ack && !mem_we) begin
                    d_rdata = bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    // Memory request registers: loaded on grant, frozen while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else if (grant_f) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= bus.f_addr;
            mem_wdata <= 32'd0;
        end else if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= bus.d_we;
            mem_addr  <= bus.d_addr;
            mem_wdata <= bus.d_wdata;
        end else if (done) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

    // Starvation counter: counts data grants that overtook a waiting fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (grant_f) begin
            starve_cnt <= 4'd0;
        end else if (grant_d && bus.f_req && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Watchdog: cycles spent busy without a memory response.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= 8'd0;
        end else if (grant_f || grant_d) begin
            wd_cnt <= 8'd0;
        end else if (busy && !bus.mem_ack) begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (wd_expire) begin
            err <= 1'b1;
        end
    end

    assign bus.f_ack     = f_ack;
    assign bus.d_ack     = d_ack;
    assign bus.f_rdata   = f_rdata;
    assign bus.d_rdata   = d_rdata;
    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.err       = err;
    assign bus.stall     = (bus.f_req & ~f_ack) | (bus.d_req & ~d_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter (STARVE_LIMIT=4, TIMEOUT=8): a table of
//   single transactions followed by hand-written multi-cycle sequences for
//   starvation, timeout, reset abort and ack-versus-timeout.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .STARVE_LIMIT (4),
        .TIMEOUT      (8)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] mem_rd;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.f_req     = 1'b0;
        bus.f_addr    = 32'd0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'd0;
        bus.d_wdata   = 32'd0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [7:0] got [6];
        logic [7:0] exp_order [6];
        int         n_grant;
        logic       own_ack;
        logic       oth_ack;
        logic [31:0] own_rd;

        // is_d we addr wdata lat mem_rd exp_we exp_wdata exp_rdata
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'hFFFF_FFFF, 1, 32'h0050_0093, 1'b0, 32'h0, 32'h0050_0093};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0040, 32'h1111_1111, 2, 32'h1234_5678, 1'b0, 32'h1111_1111, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 3, 32'hDEAD_BEEF, 1'b1, 32'hCAFE_F00D, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0204, 32'h5555_5555, 7, 32'hA5A5_A5A5, 1'b0, 32'h0, 32'hA5A5_A5A5};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_3FFC, 32'h0000_0001, 1, 32'h7777_7777, 1'b1, 32'h0000_0001, 32'h0};

        exp_order = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h46, 8'h44}; // D D D D F D

        clear_inputs();
        do_reset();
        settle();
        check("rst_mem_req",   32'(bus.mem_req),   32'd0);
        check("rst_mem_we",    32'(bus.mem_we),    32'd0);
        check("rst_mem_addr",  bus.mem_addr,       32'd0);
        check("rst_mem_wdata", bus.mem_wdata,      32'd0);
        check("rst_err",       32'(bus.err),       32'd0);
        check("rst_f_ack",     32'(bus.f_ack),     32'd0);
        check("rst_d_ack",     32'(bus.d_ack),     32'd0);
        check("rst_rdata",     bus.f_rdata | bus.d_rdata, 32'd0);
        check("rst_stall",     32'(bus.stall),     32'd0);

        // ---------------- table-driven single transactions ----------------
        for (int i = 0; i < 5; i++) begin
            bus.f_req   = !vecs[i].is_d;
            bus.d_req   = vecs[i].is_d;
            bus.d_we    = vecs[i].we;
            bus.f_addr  = vecs[i].is_d ? 32'h0BAD_0000 : vecs[i].addr;
            bus.d_addr  = vecs[i].is_d ? vecs[i].addr : 32'h0BAD_0004;
            bus.d_wdata = vecs[i].wdata;
            settle();
            check($sformatf("v%0d_stall_req", i), 32'(bus.stall), 32'd1);
            check($sformatf("v%0d_no_early_req", i), 32'(bus.mem_req), 32'd0);
            for (int k = 1; k <= vecs[i].lat; k++) begin
                tick();
                if (k == vecs[i].lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = vecs[i].mem_rd;
                end
                settle();
                own_ack = vecs[i].is_d ? bus.d_ack : bus.f_ack;
                oth_ack = vecs[i].is_d ? bus.f_ack : bus.d_ack;
                own_rd  = vecs[i].is_d ? bus.d_rdata : bus.f_rdata;
                check($sformatf("v%0d_c%0d_mem_req", i, k),   32'(bus.mem_req), 32'd1);
                check($sformatf("v%0d_c%0d_mem_addr", i, k),  bus.mem_addr,     vecs[i].addr);
                check($sformatf("v%0d_c%0d_mem_we", i, k),    32'(bus.mem_we),  32'(vecs[i].exp_we));
                check($sformatf("v%0d_c%0d_mem_wdata", i, k), bus.mem_wdata,    vecs[i].exp_wdata);
                check($sformatf("v%0d_c%0d_ack", i, k),       32'(own_ack),     32'(k == vecs[i].lat));
                check($sformatf("v%0d_c%0d_other_ack", i, k), 32'(oth_ack),     32'd0);
                if (k == vecs[i].lat) begin
                    check($sformatf("v%0d_rdata", i), own_rd, vecs[i].exp_rdata);
                    check($sformatf("v%0d_stall_ack", i), 32'(bus.stall), 32'd0);
                end else begin
                    check($sformatf("v%0d_c%0d_stall", i, k), 32'(bus.stall), 32'd1);
                end
            end
            tick();
            clear_inputs();
            settle();
            check($sformatf("v%0d_mem_req_clr", i), 32'(bus.mem_req), 32'd0);
            check($sformatf("v%0d_mem_we_clr", i),  32'(bus.mem_we),  32'd0);
        end

        // ---------------- starvation guard: D,D,D,D,F,D ----------------
        do_reset();
        bus.f_req  = 1'b1;
        bus.f_addr = 32'h0000_0800;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h0000_0900;
        n_grant = 0;
        for (int cyc = 0; cyc < 40 && n_grant < 6; cyc++) begin
            tick();
            bus.mem_ack   = bus.mem_req;
            bus.mem_rdata = 32'h0000_0001;
            settle();
            if (bus.d_ack) begin
                got[n_grant] = 8'h44;
                n_grant++;
            end else if (bus.f_ack) begin
                got[n_grant] = 8'h46;
                n_grant++;
            end
        end
        check("starve_grant_count", 32'(n_grant), 32'd6);
        for (int g = 0; g < 6; g++) begin
            if (g < n_grant) begin
                check($sformatf("starve_grant%0d", g), 32'(got[g]), 32'(exp_order[g]));
            end
        end
        tick();
        clear_inputs();
        tick();

        // ---------------- watchdog timeout, then late ack ----------------
        do_reset();
        bus.f_req     = 1'b1;
        bus.f_addr    = 32'h0000_0300;
        bus.mem_rdata = 32'hFFFF_FFFF;
        for (int k = 1; k <= 8; k++) begin
            tick();
            settle();
            check($sformatf("to_c%0d_f_ack", k), 32'(bus.f_ack), 32'(k == 8));
            check($sformatf("to_c%0d_err", k),   32'(bus.err),   32'd0);
            if (k == 8) begin
                check("to_f_rdata", bus.f_rdata, 32'd0);
            end
        end
        tick();
        bus.f_req = 1'b0;
        settle();
        check("to_err_set",     32'(bus.err),     32'd1);
        check("to_mem_req_clr", 32'(bus.mem_req), 32'd0);
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_0000;
        settle();
        check("late_f_ack", 32'(bus.f_ack), 32'd0);
        check("late_d_ack", 32'(bus.d_ack), 32'd0);
        tick();
        bus.mem_ack = 1'b0;
        settle();
        check("late_mem_req", 32'(bus.mem_req), 32'd0);
        check("late_err",     32'(bus.err),     32'd1);

        // ---------------- reset during BUSY_D ----------------
        do_reset();
        bus.f_req  = 1'b1;
        bus.f_addr = 32'h0000_0A00;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h0000_0B00;
        tick();
        settle();
        check("rmid_mem_req",  32'(bus.mem_req), 32'd1);
        check("rmid_mem_addr", bus.mem_addr,     32'h0000_0B00);
        check("rmid_starve1",  32'(u_dut.starve_cnt), 32'd1);
        tick();
        rst = 1'b1;
        settle();
        check("rmid_no_d_ack", 32'(bus.d_ack), 32'd0);
        tick();
        rst = 1'b0;
        bus.f_req     = 1'b0;
        bus.d_req     = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0F0F_0F0F;
        settle();
        check("rmid_mem_req_clr", 32'(bus.mem_req), 32'd0);
        check("rmid_late_d_ack",  32'(bus.d_ack),   32'd0);
        check("rmid_err",         32'(bus.err),     32'd0);
        check("rmid_starve0",     32'(u_dut.starve_cnt), 32'd0);
        tick();
        bus.mem_ack = 1'b0;
        settle();
        check("rmid_idle_mem_req", 32'(bus.mem_req), 32'd0);

        // ---------------- mem_ack on the last watchdog cycle ----------------
        do_reset();
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h0000_0500;
        bus.mem_rdata = 32'd0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 8) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'h1357_9BDF;
            end
            settle();
            check($sformatf("sim_c%0d_d_ack", k), 32'(bus.d_ack), 32'(k == 8));
            if (k == 8) begin
                check("sim_d_rdata", bus.d_rdata, 32'h1357_9BDF);
            end
        end
        tick();
        clear_inputs();
        settle();
        check("sim_err",     32'(bus.err),     32'd0);
        check("sim_mem_req", 32'(bus.mem_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
